// File: rtl/quad_enc_dec.sv
// Quadrature encoder front end: sync, glitch filter, 4x decode,
// step/dir pulses and signed position count.
module quad_enc_dec #(
  parameter int FILT_CYC = 4,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a,
  input  logic                    b,
  input  logic                    clr,
  output logic                    step,
  output logic                    dir,
  output logic                    err,
  output logic signed [CNT_W-1:0] pos
);

  localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam int IW = $clog2(FILT_CYC + 2) + 1;
  localparam logic [FW-1:0] FMAX = FW'(FILT_CYC - 1);
  localparam logic [IW-1:0] IMAX = IW'(FILT_CYC + 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IW-1:0] r_init_cnt;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_f;
  logic [1:0]    r_ref;
  logic [FW-1:0] r_cnt [2];

  logic       w_run;
  logic [1:0] w_idx_new;
  logic [1:0] w_idx_old;
  logic [1:0] w_diff;
  logic       w_cw;
  logic       w_ccw;
  logic       w_bad;

  // State register for the power-up settle window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // INIT holds for FILT_CYC+2 cycles, then RUN forever
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      INIT: if (r_init_cnt == IMAX) w_state_nxt = RUN;
      RUN:  w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  // Counts cycles spent in INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt <= '0;
    end else if (r_state == INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  // Two-flop synchroniser, bit 1 = A, bit 0 = B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 2'b00;
      r_s2 <= 2'b00;
    end else begin
      r_s1 <= {a, b};
      r_s2 <= r_s1;
    end
  end

  // Per-input stability filter; INIT tracks the pins directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f      <= 2'b00;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else if (r_state == INIT) begin
      r_f      <= r_s2;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_f[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == FMAX) begin
          r_f[i]   <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Map ab to a gray-cycle index so cw is +1 and ccw is -1
  always_comb begin
    w_run     = (r_state == RUN);
    w_idx_new = {r_f[0], r_f[1] ^ r_f[0]};
    w_idx_old = {r_ref[0], r_ref[1] ^ r_ref[0]};
    w_diff    = w_idx_new - w_idx_old;
    w_cw      = w_run && (w_diff == 2'd1);
    w_ccw     = w_run && (w_diff == 2'd3);
    w_bad     = w_run && (w_diff == 2'd2);
  end

  // Registered decode: pulses, direction and position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= 2'b00;
      step  <= 1'b0;
      err   <= 1'b0;
      dir   <= 1'b0;
      pos   <= '0;
    end else begin
      r_ref <= r_f;
      step  <= w_cw | w_ccw;
      err   <= w_bad;
      if (w_cw) begin
        dir <= 1'b1;
      end else if (w_ccw) begin
        dir <= 1'b0;
      end
      priority case (1'b1)
        clr:   pos <= '0;
        w_cw:  pos <= pos + 1'b1;
        w_ccw: pos <= pos - 1'b1;
        default: pos <= pos;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_enc_dec.sv
// Directed bench for quad_enc_dec: a 16-bit and a 4-bit
// counter instance share the same encoder stimulus.
module tb_quad_enc_dec;

  localparam int FILT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic clr = 1'b0;

  logic step, dir, err;
  logic signed [15:0] pos;
  logic step4, dir4, err4;
  logic signed [3:0] pos4;

  int errors = 0;
  int checks = 0;
  int n_step = 0;
  int n_err = 0;
  logic [1:0] idx = 2'd0;

  quad_enc_dec #(.FILT_CYC(FILT), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .step(step), .dir(dir), .err(err), .pos(pos)
  );

  quad_enc_dec #(.FILT_CYC(FILT), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .step(step4), .dir(dir4), .err(err4), .pos(pos4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (step) n_step++;
    if (err) n_err++;
  end

  task automatic quarter(input logic cw);
    @(negedge clk);
    idx = cw ? idx + 2'd1 : idx - 2'd1;
    a = (idx == 2'd1) || (idx == 2'd2);
    b = idx[1];
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 1'b0;
    b = 1'b0;
    idx = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({step, dir, err} !== 3'b000 || pos !== 16'sd0) begin
      errors++;
      $display("FAIL reset: step/dir/err=%b%b%b pos=%0d want 000 0",
               step, dir, err, pos);
    end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_cw();
    int s0, e0;
    s0 = n_step;
    e0 = n_err;
    repeat (4) quarter(1'b1);
    checks++;
    if (n_step - s0 !== 4) begin
      errors++;
      $display("FAIL cw_steps: got %0d want 4", n_step - s0);
    end
    checks++;
    if (dir !== 1'b1 || pos !== 16'sd4) begin
      errors++;
      $display("FAIL cw_pos: dir=%b pos=%0d want 1 4", dir, pos);
    end
    checks++;
    if (n_err != e0) begin
      errors++;
      $display("FAIL cw_err: got %0d err pulses want 0", n_err - e0);
    end
  endtask

  task automatic test_ccw();
    int s0;
    s0 = n_step;
    repeat (4) quarter(1'b0);
    checks++;
    if (n_step - s0 !== 4) begin
      errors++;
      $display("FAIL ccw_steps: got %0d want 4", n_step - s0);
    end
    checks++;
    if (dir !== 1'b0 || pos !== 16'sd0) begin
      errors++;
      $display("FAIL ccw_pos: dir=%b pos=%0d want 0 0", dir, pos);
    end
  endtask

  task automatic test_bounce();
    int s0;
    int lat;
    s0 = n_step;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      a = 1'b1;
      repeat (FILT - 1) @(negedge clk);
      a = 1'b0;
      repeat (FILT - 2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_step != s0 || pos !== 16'sd0) begin
      errors++;
      $display("FAIL bounce: steps=%0d pos=%0d want 0 0",
               n_step - s0, pos);
    end
    @(negedge clk);
    a = 1'b1;
    idx = 2'd1;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (step && lat < 0) lat = i;
    end
    checks++;
    if (lat !== FILT + 2) begin
      errors++;
      $display("FAIL latency: got %0d want %0d", lat, FILT + 2);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_step - s0 !== 1 || pos !== 16'sd1) begin
      errors++;
      $display("FAIL settle: steps=%0d pos=%0d want 1 1",
               n_step - s0, pos);
    end
    quarter(1'b0);
  endtask

  task automatic test_err();
    int s0, e0;
    s0 = n_step;
    e0 = n_err;
    @(negedge clk);
    a = 1'b1;
    b = 1'b1;
    idx = 2'd2;
    repeat (20) @(negedge clk);
    checks++;
    if (n_err - e0 !== 1) begin
      errors++;
      $display("FAIL err_pulse: got %0d cycles want 1", n_err - e0);
    end
    checks++;
    if (n_step != s0 || pos !== 16'sd0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL err_hold: steps=%0d pos=%0d dir=%b want 0 0 0",
               n_step - s0, pos, dir);
    end
    quarter(1'b1);
    checks++;
    if (pos !== 16'sd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL err_resume: pos=%0d dir=%b want 1 1", pos, dir);
    end
    quarter(1'b1);
  endtask

  task automatic test_wrap_clr();
    repeat (5) quarter(1'b1);
    checks++;
    if (pos4 !== 4'sd7) begin
      errors++;
      $display("FAIL wrap_pre: pos4=%0d want 7", pos4);
    end
    quarter(1'b1);
    checks++;
    if (pos4 !== -4'sd8 || pos !== 16'sd8) begin
      errors++;
      $display("FAIL wrap: pos4=%0d pos=%0d want -8 8", pos4, pos);
    end
    @(negedge clk);
    idx = 2'd3;
    a = 1'b0;
    b = 1'b1;
    repeat (FILT + 2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (step !== 1'b1 || dir !== 1'b1 || pos !== 16'sd0 ||
        step4 !== 1'b1 || pos4 !== 4'sd0) begin
      errors++;
      $display("FAIL clr_step: step=%b dir=%b pos=%0d pos4=%0d want 1 1 0 0",
               step, dir, pos, pos4);
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int s0, e0;
    @(negedge clk);
    a = 1'b1;
    b = 1'b1;
    idx = 2'd2;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    s0 = n_step;
    e0 = n_err;
    repeat (20) @(negedge clk);
    checks++;
    if (n_step != s0 || n_err != e0 || pos !== 16'sd0) begin
      errors++;
      $display("FAIL rest11: steps=%0d errs=%0d pos=%0d want 0 0 0",
               n_step - s0, n_err - e0, pos);
    end
    quarter(1'b1);
    checks++;
    if (pos !== 16'sd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL pre_mid: pos=%0d dir=%b want 1 1", pos, dir);
    end
    @(negedge clk);
    idx = 2'd0;
    a = 1'b0;
    b = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pos !== 16'sd0 || dir !== 1'b0 || step !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: pos=%0d dir=%b step=%b err=%b want 0 0 0 0",
               pos, dir, step, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    s0 = n_step;
    quarter(1'b1);
    checks++;
    if (pos !== 16'sd1 || dir !== 1'b1 || n_step - s0 !== 1) begin
      errors++;
      $display("FAIL post_rst: pos=%0d dir=%b steps=%0d want 1 1 1",
               pos, dir, n_step - s0);
    end
  endtask

  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_bounce();
    test_err();
    test_wrap_clr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
